// File: rtl/bcd_digit_counter_if.sv
// Control and display bus between the BCD counter and its neighbours.
// Master drives the control pulses (and direction when down-counting is built in).
// Slave is the counter: it consumes the pulses and drives the digit bus and status.
interface bcd_digit_counter_if;
  logic       start_stop;
  logic       clear;
`ifdef BCD_DIGIT_COUNTER_COUNT_DOWN_EN
  logic       down;
`endif
  logic [3:0] digit;
  logic       digit_sel;
  logic       running;
  logic       wrap;

`ifdef BCD_DIGIT_COUNTER_COUNT_DOWN_EN
  modport master (output start_stop, output clear, output down,
                  input digit, input digit_sel, input running, input wrap);
  modport slave  (input start_stop, input clear, input down,
                  output digit, output digit_sel, output running, output wrap);
`else
  modport master (output start_stop, output clear,
                  input digit, input digit_sel, input running, input wrap);
  modport slave  (input start_stop, input clear,
                  output digit, output digit_sel, output running, output wrap);
`endif
endinterface

// File: rtl/bcd_digit_counter.sv
// Two-digit BCD counter (00-99) with run/stop, prescaler and time-multiplexed digit output.
// Latency: running/count/wrap register one cycle after the causing input; digit is combinational from flops.
// Backpressure: none; inputs are single-cycle pulses and the display bus is always valid BCD.
// Optional: BCD_DIGIT_COUNTER_COUNT_DOWN_EN adds a 'down' input for decrementing with 00->99 wrap.
module bcd_digit_counter #(
  parameter int PRESCALE = 1000,
  parameter int MUX_DIV  = 16
) (
  input logic               clk,
  input logic               rst,
  bcd_digit_counter_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [MW-1:0] MUX_LAST = MW'(MUX_DIV - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [MW-1:0] mux_q, mux_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic          digit_sel_q, digit_sel_d;
  logic          running_q, running_d;
  logic          wrap_q, wrap_d;
  logic          tick;
  logic          count_down;
  logic          at_limit;

`ifdef BCD_DIGIT_COUNTER_COUNT_DOWN_EN
  assign count_down = bus.down;
`else
  assign count_down = 1'b0;
`endif

  // A step is due on the last prescaler phase, and only while running.
  assign tick = (state_q == RUN) && (presc_q == PRE_LAST);

  // Terminal value for the current direction: 99 going up, 00 going down.
  assign at_limit = count_down ? ((ones_q == 4'd0) && (tens_q == 4'd0))
                               : ((ones_q == 4'd9) && (tens_q == 4'd9));

  // Next-state logic for FSM, prescaler, BCD digits and display mux.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    ones_d      = ones_q;
    tens_d      = tens_q;
    wrap_d      = 1'b0;
    mux_d       = mux_q;
    digit_sel_d = digit_sel_q;

    if (bus.start_stop) begin
      state_d = (state_q == IDLE) ? RUN : IDLE;
    end
    running_d = (state_d == RUN);

    // Prescaler holds in IDLE so a resumed run finishes the partial period.
    if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (tick) begin
      if (count_down) begin
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end else begin
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
      wrap_d = at_limit;
    end

    // Clear wins over a coincident step and suppresses its wrap pulse.
    if (bus.clear) begin
      presc_d = '0;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
      wrap_d  = 1'b0;
    end

    // Display mux free-runs regardless of the FSM.
    if (mux_q == MUX_LAST) begin
      mux_d       = '0;
      digit_sel_d = ~digit_sel_q;
    end else begin
      mux_d = mux_q + 1'b1;
    end
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      mux_q       <= '0;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
      digit_sel_q <= 1'b0;
      running_q   <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      mux_q       <= mux_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      digit_sel_q <= digit_sel_d;
      running_q   <= running_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bus.digit     = digit_sel_q ? tens_q : ones_q;
  assign bus.digit_sel = digit_sel_q;
  assign bus.running   = running_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Bench for bcd_digit_counter: two instances (PRESCALE=4/MUX_DIV=2 and PRESCALE=1/MUX_DIV=1).
// A decimal-count model is compared every cycle; directed steps add literal expectations.
// Build with BCD_DIGIT_COUNTER_COUNT_DOWN_EN defined to also exercise down-counting.
module tb_bcd_digit_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_digit_counter_if if0 ();
  bcd_digit_counter_if if1 ();

  bcd_digit_counter #(.PRESCALE(4), .MUX_DIV(2)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  bcd_digit_counter #(.PRESCALE(1), .MUX_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic       ss  [2];
  logic       clr [2];
  logic       dn  [2];
  logic [3:0] dig [2];
  logic       sel [2];
  logic       run_o [2];
  logic       wr  [2];

  assign if0.start_stop = ss[0];
  assign if0.clear      = clr[0];
  assign if1.start_stop = ss[1];
  assign if1.clear      = clr[1];
`ifdef BCD_DIGIT_COUNTER_COUNT_DOWN_EN
  assign if0.down = dn[0];
  assign if1.down = dn[1];
`endif
  assign dig[0] = if0.digit;     assign dig[1] = if1.digit;
  assign sel[0] = if0.digit_sel; assign sel[1] = if1.digit_sel;
  assign run_o[0] = if0.running; assign run_o[1] = if1.running;
  assign wr[0] = if0.wrap;       assign wr[1] = if1.wrap;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Count kept as a decimal number 0..99; prescaler as run cycles since the last clear.
  int m_cnt [2];
  int m_el  [2];
  bit m_run [2];
  bit m_wrap[2];
  int m_cyc;

  function automatic int pre_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction
  function automatic int md_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction
  function automatic bit tick_f(input int i);
    return m_run[i] && (((m_el[i] + 1) % pre_of(i)) == 0);
  endfunction
  function automatic int step_f(input int c, input bit down);
    return down ? (c + 99) % 100 : (c + 1) % 100;
  endfunction
  function automatic bit wraps_f(input int c, input bit down);
    return down ? (c == 0) : (c == 99);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc <= 0;
      for (int i = 0; i < 2; i++) begin
        m_cnt[i]  <= 0;
        m_el[i]   <= 0;
        m_run[i]  <= 1'b0;
        m_wrap[i] <= 1'b0;
      end
    end else begin
      m_cyc <= m_cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (clr[i]) begin
          m_el[i]  <= 0;
          m_cnt[i] <= 0;
        end else begin
          if (m_run[i]) m_el[i] <= m_el[i] + 1;
          if (tick_f(i)) m_cnt[i] <= step_f(m_cnt[i], dn[i]);
        end
        m_wrap[i] <= !clr[i] && tick_f(i) && wraps_f(m_cnt[i], dn[i]);
        if (ss[i]) m_run[i] <= !m_run[i];
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int i = 0; i < 2; i++) begin
        chk("cyc_running", int'(run_o[i]), int'(m_run[i]));
        chk("cyc_wrap", int'(wr[i]), int'(m_wrap[i]));
        chk("cyc_sel", int'(sel[i]), (m_cyc / md_of(i)) % 2);
        chk("cyc_digit", int'(dig[i]),
            (((m_cyc / md_of(i)) % 2) == 1) ? m_cnt[i] / 10 : m_cnt[i] % 10);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic pulse_ss(input int i);
    ss[i] = 1'b1;
    @(negedge clk);
    ss[i] = 1'b0;
  endtask

  task automatic pulse_clr(input int i);
    clr[i] = 1'b1;
    @(negedge clk);
    clr[i] = 1'b0;
  endtask

  // Checks the shown digit against a literal two-digit count for whichever digit is selected.
  task automatic chk_count(input int i, input int val, input string name);
    chk(name, int'(dig[i]), sel[i] ? val / 10 : val % 10);
  endtask

  int nw, wk;

  initial begin
    for (int i = 0; i < 2; i++) begin
      ss[i] = 1'b0; clr[i] = 1'b0; dn[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_running0", int'(run_o[0]), 0);
    chk("rst_digit0", int'(dig[0]), 0);
    chk("rst_sel0", int'(sel[0]), 0);
    chk("rst_wrap1", int'(wr[1]), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Display mux after release: MUX_DIV=2 toggles every 2 cycles, MUX_DIV=1 every cycle.
    @(negedge clk);
    chk("mux0_k1", int'(sel[0]), 0);
    chk("mux1_k1", int'(sel[1]), 1);
    @(negedge clk);
    chk("mux0_k2", int'(sel[0]), 1);
    chk("mux1_k2", int'(sel[1]), 0);
    @(negedge clk);
    chk("mux0_k3", int'(sel[0]), 1);
    @(negedge clk);
    chk("mux0_k4", int'(sel[0]), 0);
    chk_count(0, 0, "idle_count0");

    // Basic counting to 13 with PRESCALE=4, then freeze and view both digits.
    pulse_ss(0);
    repeat (52) @(negedge clk);
    chk("count13_running", int'(run_o[0]), 1);
    chk_count(0, 13, "count13_a");
    pulse_ss(0);
    chk_count(0, 13, "count13_b");
    repeat (2) @(negedge clk);
    chk_count(0, 13, "count13_c");
    chk("count13_stopped", int'(run_o[0]), 0);

    // Stop after 6 RUN cycles, idle, resume: next step lands 2 cycles after restart.
    pulse_clr(0);
    chk_count(0, 0, "clr_idle");
    pulse_ss(0);
    repeat (5) @(negedge clk);
    pulse_ss(0);
    chk_count(0, 1, "stop_at_01");
    repeat (20) @(negedge clk);
    chk_count(0, 1, "idle_hold_01");
    pulse_ss(0);
    chk_count(0, 1, "resume_r0");
    @(negedge clk);
    chk_count(0, 1, "resume_r1");
    @(negedge clk);
    chk_count(0, 2, "resume_r2");

    // Wrap with PRESCALE=1: 100 steps from 00, exactly one wrap pulse at the 100th.
    pulse_ss(1);
    nw = 0;
    wk = -1;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      if (wr[1]) begin
        nw++;
        wk = k;
      end
      if (k == 100) chk_count(1, 0, "wrap_count00");
    end
    chk("wrap_pulses", nw, 1);
    chk("wrap_cycle", wk, 100);
    chk("wrap_running", int'(run_o[1]), 1);

    // Clear coinciding with the 99->00 step: count 00 and no wrap.
    pulse_clr(1);
    chk_count(1, 0, "clr_run_00");
    repeat (99) @(negedge clk);
    chk_count(1, 99, "reach_99");
    pulse_clr(1);
    chk_count(1, 0, "clr_tick_00");
    chk("clr_tick_nowrap", int'(wr[1]), 0);
    @(negedge clk);
    chk("clr_tick_nowrap2", int'(wr[1]), 0);

    // Clear and start_stop together in RUN.
    clr[1] = 1'b1;
    ss[1]  = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    ss[1]  = 1'b0;
    chk("clr_ss_idle", int'(run_o[1]), 0);
    chk_count(1, 0, "clr_ss_00");
    @(negedge clk);
    chk_count(1, 0, "clr_ss_hold");

`ifdef BCD_DIGIT_COUNTER_COUNT_DOWN_EN
    // Down-count from 00: 99 with wrap, 98, then direction flips affect only the next step.
    dn[1] = 1'b1;
    pulse_ss(1);
    @(negedge clk);
    chk_count(1, 99, "down_99");
    chk("down_wrap", int'(wr[1]), 1);
    @(negedge clk);
    chk_count(1, 98, "down_98");
    chk("down_nowrap", int'(wr[1]), 0);
    dn[1] = 1'b0;
    @(negedge clk);
    chk_count(1, 99, "down_flip_up");
    dn[1] = 1'b1;
    @(negedge clk);
    chk_count(1, 98, "down_flip_back");
    pulse_ss(1);
    dn[1] = 1'b0;
`endif

    // Asynchronous reset mid-cycle while counting.
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_running0", int'(run_o[0]), 0);
    chk("arst_digit0", int'(dig[0]), 0);
    chk("arst_sel0", int'(sel[0]), 0);
    chk("arst_wrap0", int'(wr[0]), 0);
    chk("arst_digit1", int'(dig[1]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_arst_running", int'(run_o[0]), 0);
    chk_count(0, 0, "post_arst_count");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/bcd_digit_counter.md
Name: bcd_digit_counter

Overview:
Two-digit BCD counter (00-99) with a run/stop control and a clock prescaler. It sits directly upstream of the 7-segment digit decoder. It time-multiplexes its ones and tens digits onto a single 4-bit digit bus, plus a digit-select line that drives the common anodes/cathodes. Outputs are always valid BCD (0-9), so the decoder never sees codes 10-15.

Parameters:
PRESCALE, 1000, clk cycles per count step; legal range >= 1.
MUX_DIV, 16, clk cycles each digit is shown before digit_sel flips; legal range >= 1.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start_stop  input  1  single-cycle pulse; toggles IDLE/RUN
clear  input  1  synchronous clear of count and prescaler
digit  output  4  BCD value of the currently selected digit, to the decoder
digit_sel  output  1  0 = ones digit on bus, 1 = tens digit on bus
running  output  1  1 while in RUN
wrap  output  1  one-cycle pulse on 99->00 (and 00->99 with the optional feature)

Behaviour:
- Reset: one clock (clk); reset rst is asynchronous, active-high. While rst=1: state=IDLE, ones=0, tens=0, prescaler=0, mux counter=0, digit_sel=0, running=0, wrap=0, digit=0.
- FSM has two states:
  - IDLE -> RUN on start_stop=1.
  - RUN -> IDLE on start_stop=1.
  - running = (state==RUN); registered, so it changes the cycle after the pulse.
- Prescaler:
  - Width is clog2(PRESCALE), minimum 1 bit.
  - Advances only in RUN. Counts 0..PRESCALE-1. At PRESCALE-1 it asserts an internal tick and returns to 0.
  - In IDLE it holds its value, so resuming continues the partial period.
  - PRESCALE=1: tick every RUN cycle.
- Count step, on tick:
  - ones<9: ones+1.
  - ones=9: ones=0, and tens+1.
  - tens=9 and ones=9: both become 0 and wrap=1 for exactly one cycle.
  - Count registers update the cycle after the tick condition.
- First tick after entering RUN from reset occurs PRESCALE cycles after running rises.
- clear:
  - Zeroes ones, tens and prescaler next cycle. Overrides a same-cycle tick, and no wrap pulse is produced.
  - Does not change FSM state.
  - clear and start_stop in the same cycle: both take effect.
- Display mux:
  - Free-running counter 0..MUX_DIV-1, independent of the FSM; it runs in IDLE too.
  - At the terminal count, digit_sel inverts.
  - digit = digit_sel ? tens : ones. Combinational from registered values; no extra latency.
  - MUX_DIV=1: digit_sel toggles every cycle.
- Invariant: ones and tens are never > 9.
- Reset mid-count: immediate return to all-zero IDLE. No pulse is emitted on wrap.

Optional Feature:
Macro: BCD_DIGIT_COUNTER_COUNT_DOWN_EN.
- Defined:
  - Adds input port `down` (1 bit), listed after clear.
  - When down=1 at a tick: ones>0 gives ones-1; ones=0 gives ones=9 and a borrow from tens.
  - 00 -> 99 with a one-cycle wrap pulse.
  - down is sampled only on tick cycles, so a mid-period change affects the next step only.
  - clear is unaffected.
- Undefined: no down port; the counter is up-only as above.

Test Plan:
- Reset values: assert rst asynchronously mid-cycle with PRESCALE=4, MUX_DIV=2 -> all outputs 0 immediately; after release, digit_sel toggles every 2 cycles and the count stays 00 while IDLE.
- Basic counting: PRESCALE=4; pulse start_stop, wait 4*13 cycles -> count=13, with ones=3 shown when digit_sel=0 and tens=1 when digit_sel=1; running=1.
- Wrap: PRESCALE=1; run 100 ticks from 00 -> count returns to 00 and wrap is high for exactly one cycle at the 99->00 step; running stays 1.
- Stop/resume: PRESCALE=4; stop after 6 cycles in RUN (count=01, prescaler=2); idle 20 cycles -> count unchanged at 01; restart -> next increment to 02 arrives 2 cycles later.
- Clear priority: clear asserted on the same cycle as a tick at count 99 -> count 00, no wrap pulse. Clear plus start_stop together in RUN -> count 00 and state IDLE.
- Count-down (macro defined): down=1, PRESCALE=1, start at 00 -> next count 99 with a wrap pulse, then 98. Toggling down between ticks changes only the following step.
